riscv_bht: RTL and testbench

Branch history table and target buffer for the fetch stage of the RV64IMAC core. Each cycle it predicts taken/not-taken and a target for the fetch PC using 2-bit saturating counters. It is trained one cycle later by the execute-stage branch comparator's resolved outcome (taken flag, PC, target). It is direct-mapped, supports 16-bit compressed instructions (halfword-granular indexing), and is cleared by a pipeline/fence flush.

---
 rtl/riscv_bht.sv | 104 ++++++++++
 tb/tb_riscv_bht.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/riscv_bht.sv
// Direct-mapped branch history table / target buffer with 2-bit counters, halfword indexing.
// Optional macro RISCV_BHT_BYPASS_EN forwards a same-cycle update to a matching lookup.
module riscv_bht #(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 64
) (
    input  logic            i_riscv_bht_clk,
    input  logic            i_riscv_bht_rst_n,
    input  logic [XLEN-1:0] i_riscv_bht_fetch_pc,
    output logic            o_riscv_bht_pred_taken,
    output logic [XLEN-1:0] o_riscv_bht_pred_target,
    input  logic            i_riscv_bht_upd_en,
    input  logic [XLEN-1:0] i_riscv_bht_upd_pc,
    input  logic            i_riscv_bht_upd_taken,
    input  logic [XLEN-1:0] i_riscv_bht_upd_target,
    input  logic            i_riscv_bht_flush
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 1;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr    [ENTRIES];
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [XLEN-1:0]    target [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;

    assign f_idx = i_riscv_bht_fetch_pc[IDX_W:1];
    assign f_tag = i_riscv_bht_fetch_pc[XLEN-1:IDX_W+1];
    assign u_idx = i_riscv_bht_upd_pc[IDX_W:1];
    assign u_tag = i_riscv_bht_upd_pc[XLEN-1:IDX_W+1];

    logic            u_hit;
    logic            wr;
    logic [1:0]      n_ctr;
    logic [XLEN-1:0] n_tgt;

    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

    // Post-update value of the entry at u_idx; shared by the write port and the bypass path.
    always_comb begin
        wr    = 1'b0;
        n_ctr = ctr[u_idx];
        n_tgt = target[u_idx];
        if (i_riscv_bht_upd_en) begin
            if (u_hit) begin
                wr = 1'b1;
                if (i_riscv_bht_upd_taken) begin
                    n_ctr = (ctr[u_idx] == 2'b11) ? 2'b11 : ctr[u_idx] + 2'b01;
                    n_tgt = i_riscv_bht_upd_target;
                end else begin
                    n_ctr = (ctr[u_idx] == 2'b00) ? 2'b00 : ctr[u_idx] - 2'b01;
                end
            end else if (i_riscv_bht_upd_taken) begin
                wr    = 1'b1;
                n_ctr = 2'b10;
                n_tgt = i_riscv_bht_upd_target;
            end
        end
    end

    always_ff @(posedge i_riscv_bht_clk or negedge i_riscv_bht_rst_n) begin
        if (!i_riscv_bht_rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (i_riscv_bht_flush) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (wr) begin
            valid[u_idx] <= 1'b1;
            ctr[u_idx]   <= n_ctr;
        end
    end

    // Tags and targets are meaningless while the valid bit is clear, so they carry no reset.
    always_ff @(posedge i_riscv_bht_clk) begin
        if (!i_riscv_bht_flush && wr) begin
            tag[u_idx]    <= u_tag;
            target[u_idx] <= n_tgt;
        end
    end

    logic            l_hit;
    logic            l_ctr1;
    logic [XLEN-1:0] l_tgt;

    always_comb begin
        l_hit  = valid[f_idx] && (tag[f_idx] == f_tag);
        l_ctr1 = ctr[f_idx][1];
        l_tgt  = target[f_idx];
`ifdef RISCV_BHT_BYPASS_EN
        if (wr && !i_riscv_bht_flush && (u_idx == f_idx) && (u_tag == f_tag)) begin
            l_hit  = 1'b1;
            l_ctr1 = n_ctr[1];
            l_tgt  = n_tgt;
        end
`endif
    end

    assign o_riscv_bht_pred_taken  = l_hit && l_ctr1;
    assign o_riscv_bht_pred_target = o_riscv_bht_pred_taken ? l_tgt : '0;

endmodule

// File: tb/tb_riscv_bht.sv
// Scoreboard bench for riscv_bht: stimulus pushes expected predictions, a negedge monitor compares.
module tb_riscv_bht;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_en;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            flush;

    riscv_bht #(.ENTRIES(64), .XLEN(XLEN)) dut (
        .i_riscv_bht_clk        (clk),
        .i_riscv_bht_rst_n      (rst_n),
        .i_riscv_bht_fetch_pc   (fetch_pc),
        .o_riscv_bht_pred_taken (pred_taken),
        .o_riscv_bht_pred_target(pred_target),
        .i_riscv_bht_upd_en     (upd_en),
        .i_riscv_bht_upd_pc     (upd_pc),
        .i_riscv_bht_upd_taken  (upd_taken),
        .i_riscv_bht_upd_target (upd_target),
        .i_riscv_bht_flush      (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] tgt;
        string           name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            if (pred_taken !== mon_e.taken || pred_target !== mon_e.tgt) begin
                failures++;
                $display("FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
                         mon_e.name, pred_taken, pred_target, mon_e.taken, mon_e.tgt);
            end
        end
    end

    task automatic cyc(input logic [XLEN-1:0] fpc, input logic ue, input logic [XLEN-1:0] upc,
                       input logic ut, input logic [XLEN-1:0] utg, input logic fl,
                       input logic chk, input logic et, input logic [XLEN-1:0] etg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        fetch_pc   = fpc;
        upd_en     = ue;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        flush      = fl;
        if (chk) begin
            e.taken = et;
            e.tgt   = etg;
            e.name  = nm;
            q.push_back(e);
        end
    endtask

    task automatic look(input logic [XLEN-1:0] pc, input logic et, input logic [XLEN-1:0] etg,
                        input string nm);
        cyc(pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, et, etg, nm);
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input logic t, input logic [XLEN-1:0] tg);
        cyc('0, 1'b1, pc, t, tg, 1'b0, 1'b0, 1'b0, '0, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; fetch_pc = '0; upd_en = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        look(64'h100,         1'b0, 64'h0, "reset_0x100");
        look(64'h8000_0002,   1'b0, 64'h0, "reset_0x80000002");

        upd(64'h100, 1'b1, 64'h200);
        look(64'h100, 1'b1, 64'h200, "alloc_hit");
        look(64'h101, 1'b1, 64'h200, "pc0_ignored");
        look(64'h102, 1'b0, 64'h0,   "neighbour_miss");

        upd(64'h100, 1'b1, 64'h200);
        upd(64'h100, 1'b1, 64'h200);
        upd(64'h100, 1'b1, 64'h240);
        look(64'h100, 1'b1, 64'h240, "ctr11_target_overwrite");
        upd(64'h100, 1'b0, 64'h999);
        look(64'h100, 1'b1, 64'h240, "ctr10_after_nt");
        upd(64'h100, 1'b0, 64'h0);
        look(64'h100, 1'b0, 64'h0,   "ctr01_not_taken");
        upd(64'h100, 1'b0, 64'h0);
        upd(64'h100, 1'b0, 64'h0);
        look(64'h100, 1'b0, 64'h0,   "ctr00_sat");
        upd(64'h100, 1'b1, 64'h260);
        look(64'h100, 1'b0, 64'h0,   "ctr01_from_sat");
        upd(64'h100, 1'b1, 64'h260);
        look(64'h100, 1'b1, 64'h260, "ctr10_retrained");

        look(64'h180, 1'b0, 64'h0,   "alias_miss");
        upd(64'h180, 1'b1, 64'h40);
        look(64'h100, 1'b0, 64'h0,   "evicted_0x100");
        look(64'h180, 1'b1, 64'h40,  "alias_alloc");
        upd(64'h300, 1'b0, 64'h80);
        look(64'h300, 1'b0, 64'h0,   "nt_miss_no_alloc");
        look(64'h180, 1'b1, 64'h40,  "nt_miss_keeps_occupant");

        cyc(64'h180, 1'b1, 64'h100, 1'b1, 64'h200, 1'b1, 1'b1, 1'b1, 64'h40, "pre_flush_lookup");
        look(64'h100, 1'b0, 64'h0,   "flush_dropped_update");
        look(64'h180, 1'b0, 64'h0,   "flush_cleared");

`ifdef RISCV_BHT_BYPASS_EN
        cyc(64'h100, 1'b1, 64'h100, 1'b1, 64'h200, 1'b0, 1'b1, 1'b1, 64'h200, "same_cycle_alloc");
`else
        cyc(64'h100, 1'b1, 64'h100, 1'b1, 64'h200, 1'b0, 1'b1, 1'b0, 64'h0,   "same_cycle_alloc");
`endif
        look(64'h100, 1'b1, 64'h200, "after_same_cycle_alloc");
`ifdef RISCV_BHT_BYPASS_EN
        cyc(64'h100, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,   "same_cycle_nt");
`else
        cyc(64'h100, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h200, "same_cycle_nt");
`endif
        look(64'h100, 1'b0, 64'h0,   "after_same_cycle_nt");

        upd(64'h100, 1'b1, 64'h300);
        look(64'h100, 1'b1, 64'h300, "before_async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        e.taken = 1'b0; e.tgt = '0; e.name = "async_reset_comb";
        q.push_back(e);
        @(posedge clk);
        #1 rst_n = 1'b1;
        look(64'h100, 1'b0, 64'h0,   "after_async_reset");

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
